// File: rtl/ica_pkg.sv
// Shared constants, word type and loader state encoding for the ICA front end.
package ica_pkg;
  localparam int DW          = 16;
  localparam int N_CH        = 3;
  localparam int N_SMP       = 64;
  localparam int FRAME_WORDS = N_CH * N_CH + N_CH * N_SMP;

  typedef logic signed [DW-1:0] ica_word_t;

  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    LOAD_X = 2'd1,
    HOLD   = 2'd2
  } ld_state_t;
endpackage

// File: rtl/ica_frame_loader_if.sv
// Valid/ready word stream with frame delimiter feeding the frame loader.
interface ica_frame_loader_if #(
  parameter int DW = ica_pkg::DW
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/ica_idx_ctr.sv
// Nested index counter: inner wraps at INNER and carries into outer, which wraps at OUTER.
module ica_idx_ctr #(
  parameter int INNER = 64,
  parameter int OUTER = 3,
  parameter int IW    = $clog2(INNER),
  parameter int OW    = $clog2(OUTER)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [IW-1:0] inner,
  output logic [OW-1:0] outer,
  output logic          last
);
  logic inner_wrap;

  assign inner_wrap = (inner == IW'(INNER - 1));
  assign last       = inner_wrap && (outer == OW'(OUTER - 1));

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      inner <= '0;
      outer <= '0;
    end else if (inc) begin
      if (inner_wrap) begin
        inner <= '0;
        outer <= (outer == OW'(OUTER - 1)) ? '0 : outer + OW'(1);
      end else begin
        inner <= inner + IW'(1);
      end
    end
  end
endmodule

// File: rtl/ica_frame_loader.sv
// Assembles a w/x frame from the word stream, presents it with frame_valid until acked.
module ica_frame_loader #(
  parameter int DW    = ica_pkg::DW,
  parameter int N_CH  = ica_pkg::N_CH,
  parameter int N_SMP = ica_pkg::N_SMP
) (
  input  logic                 clk,
  input  logic                 reset,
  ica_frame_loader_if.slave    strm,
  output logic signed [DW-1:0] w_out [0:N_CH-1][0:N_CH-1],
  output logic signed [DW-1:0] x_out [0:N_CH-1][0:N_SMP-1],
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic                 frm_err,
  output logic [7:0]           frame_cnt
);
  import ica_pkg::*;

  localparam int W_WORDS = N_CH * N_CH;
  localparam int WIW     = $clog2(W_WORDS);
  localparam int CHW     = $clog2(N_CH);
  localparam int NW      = $clog2(N_SMP);

  ld_state_t      state_reg;
  logic [WIW-1:0] wi_reg;
  logic [CHW-1:0] ch;
  logic [NW-1:0]  n;
  logic           x_last;
  logic           hs;
  logic           w_last;
  logic           ctr_clr;
  logic           ctr_inc;
  logic           w_en [0:N_CH-1][0:N_CH-1];
  logic           x_en [0:N_CH-1][0:N_SMP-1];

  assign strm.s_ready = reset & (state_reg != HOLD);
  assign hs           = strm.s_valid & strm.s_ready;
  assign w_last       = (wi_reg == WIW'(W_WORDS - 1));

  // ch/n also clear on any s_last in LOAD_X: a good end, an early end, or the missing-last case.
  assign ctr_inc = hs && (state_reg == LOAD_X);
  assign ctr_clr = (ctr_inc && (strm.s_last || x_last)) ||
                   ((state_reg == HOLD) && frame_ack);

  ica_idx_ctr #(
    .INNER (N_SMP),
    .OUTER (N_CH)
  ) u_idx_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .inc   (ctr_inc),
    .inner (n),
    .outer (ch),
    .last  (x_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= LOAD_W;
      wi_reg      <= '0;
      frame_valid <= 1'b0;
      frm_err     <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frm_err <= 1'b0;
      case (state_reg)
        LOAD_W: if (hs) begin
          if (strm.s_last) begin
            frm_err <= 1'b1;
            wi_reg  <= '0;
          end else if (w_last) begin
            wi_reg    <= '0;
            state_reg <= LOAD_X;
          end else begin
            wi_reg <= wi_reg + WIW'(1);
          end
        end
        LOAD_X: if (hs) begin
          if (x_last && strm.s_last) begin
            state_reg   <= HOLD;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
          end else if (x_last || strm.s_last) begin
            frm_err   <= 1'b1;
            state_reg <= LOAD_W;
          end
        end
        HOLD: if (frame_ack) begin
          frame_valid <= 1'b0;
          state_reg   <= LOAD_W;
        end
        default: state_reg <= LOAD_W;
      endcase
    end
  end

  // One write enable per array element, decoded from state and the running index.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_w_row
    for (genvar gc = 0; gc < N_CH; gc++) begin : g_w_col
      assign w_en[gi][gc] = hs && (state_reg == LOAD_W) && (wi_reg == WIW'(gi * N_CH + gc));
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_x_ch
    for (genvar gn = 0; gn < N_SMP; gn++) begin : g_x_smp
      assign x_en[gi][gn] = hs && (state_reg == LOAD_X) && (ch == CHW'(gi)) && (n == NW'(gn));
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < N_CH; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!reset) begin
          w_out[r][c] <= '0;
        end else if (w_en[r][c]) begin
          w_out[r][c] <= strm.s_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < N_CH; r++) begin
      for (int k = 0; k < N_SMP; k++) begin
        if (!reset) begin
          x_out[r][k] <= '0;
        end else if (x_en[r][k]) begin
          x_out[r][k] <= strm.s_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_ica_frame_loader.sv
// Directed bench for ica_frame_loader: reset, nominal, backpressure/hold, framing errors, mid-frame reset.
module tb_ica_frame_loader;
  import ica_pkg::*;

  logic clk;
  logic reset;
  logic frame_ack;
  logic frame_valid;
  logic frm_err;
  logic [7:0] frame_cnt;
  ica_word_t w_out [0:N_CH-1][0:N_CH-1];
  ica_word_t x_out [0:N_CH-1][0:N_SMP-1];

  int errors = 0;
  int checks = 0;

  ica_frame_loader_if #(.DW(DW)) strm ();

  ica_frame_loader dut (
    .clk         (clk),
    .reset       (reset),
    .strm        (strm),
    .w_out       (w_out),
    .x_out       (x_out),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frm_err     (frm_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    strm.s_valid = 1'b0;
    strm.s_last  = 1'b0;
    repeat (cycles) tick();
  endtask

  // Sends count words base+i; s_last asserted on word last_at (-1 = never).
  task automatic send_frame(input int base, input bit gaps, input int last_at, input int count);
    for (int i = 0; i < count; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) idle(1);
      if (i == count - 1) chk("fv_low_before_last_word", frame_valid, 0);
      strm.s_valid = 1'b1;
      strm.s_data  = 16'(base + i);
      strm.s_last  = (i == last_at);
      tick();
    end
    strm.s_valid = 1'b0;
    strm.s_last  = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("ack_fv_low", frame_valid, 0);
    chk("ack_ready_high", strm.s_ready, 1);
  endtask

  initial begin
    reset        = 1'b0;
    frame_ack    = 1'b0;
    strm.s_valid = 1'b1;
    strm.s_data  = 16'sd77;
    strm.s_last  = 1'b0;
    repeat (3) tick();
    $display("reset held 3 cycles");
    chk("rst_ready", strm.s_ready, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_err", frm_err, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_w12", w_out[1][2], 0);
    chk("rst_x263", x_out[2][63], 0);
    strm.s_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_rst_ready", strm.s_ready, 1);

    send_frame(0, 0, 200, 201);
    $display("nominal frame sent");
    chk("nom_fv", frame_valid, 1);
    chk("nom_ready", strm.s_ready, 0);
    chk("nom_w12", w_out[1][2], 5);
    chk("nom_x00", x_out[0][0], 9);
    chk("nom_x263", x_out[2][63], 200);
    chk("nom_cnt", frame_cnt, 1);

    strm.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strm.s_data = (i % 2 == 0) ? 16'sh7fff : -16'sd1;
      tick();
    end
    strm.s_valid = 1'b0;
    $display("hold with toggling data");
    chk("hold_fv", frame_valid, 1);
    chk("hold_w00", w_out[0][0], 0);
    chk("hold_x15", x_out[1][5], 78);
    ack();

    send_frame(1000, 1, 200, 201);
    $display("backpressured frame sent");
    chk("bp_fv", frame_valid, 1);
    chk("bp_x10", x_out[1][0], 1073);
    chk("bp_w22", w_out[2][2], 1008);
    chk("bp_cnt", frame_cnt, 2);
    ack();

    send_frame(2000, 0, 50, 51);
    $display("early last on word 50");
    chk("early_err", frm_err, 1);
    chk("early_fv", frame_valid, 0);
    idle(1);
    chk("early_err_pulse", frm_err, 0);
    send_frame(3000, 0, 200, 201);
    $display("good frame after early last");
    chk("early_next_fv", frame_valid, 1);
    chk("early_next_cnt", frame_cnt, 3);
    chk("early_next_w00", w_out[0][0], 3000);
    chk("early_next_x263", x_out[2][63], 3200);
    ack();

    send_frame(4000, 0, -1, 201);
    $display("missing last on word 200");
    chk("miss_err", frm_err, 1);
    chk("miss_fv", frame_valid, 0);
    chk("miss_ready", strm.s_ready, 1);
    chk("miss_cnt", frame_cnt, 3);
    idle(1);
    chk("miss_err_pulse", frm_err, 0);
    send_frame(-500, 0, 200, 201);
    $display("signed frame after missing last");
    chk("miss_next_fv", frame_valid, 1);
    chk("miss_next_w00", w_out[0][0], -500);
    chk("miss_next_x00", x_out[0][0], -491);
    chk("miss_next_cnt", frame_cnt, 4);
    ack();

    send_frame(6000, 0, -1, 100);
    reset = 1'b0;
    tick();
    $display("reset at word 100");
    chk("mid_rst_w00", w_out[0][0], 0);
    chk("mid_rst_x126", x_out[1][26], 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_fv", frame_valid, 0);
    reset = 1'b1;
    tick();
    send_frame(0, 0, 200, 201);
    $display("frame after mid-frame reset");
    chk("after_rst_fv", frame_valid, 1);
    chk("after_rst_w00", w_out[0][0], 0);
    chk("after_rst_x263", x_out[2][63], 200);
    chk("after_rst_cnt", frame_cnt, 1);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
